const_seq_gen: RTL

Parametrised successor to the fixed-constant source blocks. It emits a WIDTH-bit value that is either a constant or a sequence (wrapping ramp, saturating ramp, or triangle) between START and LIMIT. It sits at datapath inputs, where fixed operands, address ramps or test patterns are needed. It keeps the standard init/disable control pair and adds run-time load plus valid/wrap/done status.

---
 rtl/const_seq_gen_pkg.sv | 28 ++
 rtl/const_seq_gen_step.sv | 88 ++++++++
 rtl/const_seq_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/const_seq_gen_pkg.sv
// Shared definitions for the constant/sequence source: mode codes, the
// sequence direction state, and the load clamp helper.
// No ports; imported by const_seq_gen and const_seq_gen_step.
package const_seq_gen_pkg;

  // Sequence modes selected by the MODE parameter
  localparam int MODE_CONST = 0;
  localparam int MODE_WRAP  = 1;
  localparam int MODE_SAT   = 2;
  localparam int MODE_TRI   = 3;

  // DOWN is only used by the triangle mode, HOLD only by the saturating mode
  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Restrict a run-time load value to the legal [lo, hi] window
  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/const_seq_gen_step.sv
// Purpose: combinational next-step arithmetic for the sequence generator.
// Latency: none (pure combinational).
// Backpressure: none; the caller decides whether the step is taken.
// Ports: value/state in -> nxt_value, nxt_state, wrap pulse, done level out.
module const_seq_gen_step
  import const_seq_gen_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int START = 3,
  parameter int STEP  = 1,
  parameter int LIMIT = 4095,
  parameter int MODE  = MODE_CONST
) (
  input  logic [WIDTH-1:0] value,
  input  state_t           state,
  output logic [WIDTH-1:0] nxt_value,
  output state_t           nxt_state,
  output logic             wrap,
  output logic             done
);

  localparam int W1 = WIDTH + 1;

  // One extra bit of headroom so value + STEP can never silently overflow
  localparam logic [WIDTH:0]   STEP_W  = W1'(STEP);
  localparam logic [WIDTH:0]   START_W = W1'(START);
  localparam logic [WIDTH:0]   LIMIT_W = W1'(LIMIT);
  localparam logic [WIDTH:0]   LOW_THR = START_W + STEP_W;
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH:0] up_sum;
  assign up_sum = {1'b0, value} + STEP_W;

  always_comb begin
    nxt_value = value;
    nxt_state = state;
    wrap      = 1'b0;
    done      = 1'b0;
    // A zero step degenerates every mode into a constant source
    if (STEP != 0) begin
      case (MODE)
        MODE_WRAP: begin
          if (up_sum > LIMIT_W) begin
            nxt_value = START_V;
            wrap      = 1'b1;
          end else begin
            nxt_value = up_sum[WIDTH-1:0];
          end
        end
        MODE_SAT: begin
          if (state != ST_HOLD) begin
            if (up_sum >= LIMIT_W) begin
              nxt_value = LIMIT_V;
              nxt_state = ST_HOLD;
              wrap      = 1'b1;
            end else begin
              nxt_value = up_sum[WIDTH-1:0];
            end
          end
        end
        MODE_TRI: begin
          if (state == ST_DOWN) begin
            // Compare before subtracting so the descent never dips below START
            if ({1'b0, value} < LOW_THR) begin
              nxt_value = START_V;
              nxt_state = ST_UP;
              wrap      = 1'b1;
            end else begin
              nxt_value = value - STEP_V;
            end
          end else begin
            if (up_sum >= LIMIT_W) begin
              nxt_value = LIMIT_V;
              nxt_state = ST_DOWN;
            end else begin
              nxt_value = up_sum[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
    done = (nxt_state == ST_HOLD);
  end

endmodule

// File: rtl/const_seq_gen.sv
// Purpose: constant or sequence source (wrap/saturate/triangle ramp) with load.
// Latency: one cycle from an enabled edge or load to the new out_value.
// Backpressure: none; in_disable freezes the sequence and drops out_valid.
// Ports: clk, async reset, sync init, in_disable, in_load/in_value ->
//        out_value, out_valid, out_wrap (pulse), out_done (SAT level).
module const_seq_gen
  import const_seq_gen_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int START = 3,
  parameter int STEP  = 1,
  parameter int LIMIT = 4095,
  parameter int MODE  = MODE_CONST
) (
  input  logic             const_seq_gen_clk,
  input  logic             const_seq_gen_reset,
  input  logic             const_seq_gen_init,
  input  logic             const_seq_gen_in_disable,
  input  logic             const_seq_gen_in_load,
  input  logic [WIDTH-1:0] const_seq_gen_in_value,
  output logic [WIDTH-1:0] const_seq_gen_out_value,
  output logic             const_seq_gen_out_valid,
  output logic             const_seq_gen_out_wrap,
  output logic             const_seq_gen_out_done
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  logic [WIDTH-1:0] value_q;
  state_t           state_q;
  logic             valid_q;
  logic             wrap_q;
  logic             done_q;

  logic [WIDTH-1:0] step_value;
  state_t           step_state;
  logic             step_wrap;
  logic             step_done;
  logic [WIDTH-1:0] load_value;

  const_seq_gen_step #(
    .WIDTH (WIDTH),
    .START (START),
    .STEP  (STEP),
    .LIMIT (LIMIT),
    .MODE  (MODE)
  ) u_step (
    .value     (value_q),
    .state     (state_q),
    .nxt_value (step_value),
    .nxt_state (step_state),
    .wrap      (step_wrap),
    .done      (step_done)
  );

  assign load_value = WIDTH'(clamp(32'(const_seq_gen_in_value), 32'(START), 32'(LIMIT)));

  // Priority: init > disable > load > step
  always_ff @(posedge const_seq_gen_clk or posedge const_seq_gen_reset) begin
    if (const_seq_gen_reset) begin
      value_q <= START_V;
      state_q <= ST_UP;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (const_seq_gen_init) begin
      value_q <= START_V;
      state_q <= ST_UP;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (const_seq_gen_in_disable) begin
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (const_seq_gen_in_load) begin
        value_q <= load_value;
        state_q <= ST_UP;
        wrap_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        value_q <= step_value;
        state_q <= step_state;
        wrap_q  <= step_wrap;
        done_q  <= step_done;
      end
    end
  end

  assign const_seq_gen_out_value = value_q;
  assign const_seq_gen_out_valid = valid_q;
  assign const_seq_gen_out_wrap  = wrap_q;
  assign const_seq_gen_out_done  = done_q;

endmodule
